// File: rtl/rr_sched_pkg.sv
// Shared types and constants for the round-robin decode scheduler.
package rr_sched_pkg;

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDXW = 3;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  typedef enum logic [1:0] {
    REL_NONE,
    REL_DONE,
    REL_WITHDRAW,
    REL_TIMEOUT
  } rel_cause_t;

endpackage

// File: rtl/rr_decode_scheduler_decoder.sv
// 3-to-8 one-hot decoder driving the downstream select/enable fabric.
module decoder_3to8
  import rr_sched_pkg::*;
(
  input  logic [IDXW-1:0] i_idx,
  output logic [NREQ-1:0] o_onehot
);

  always_comb begin
    o_onehot        = '0;
    o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_decode_scheduler.sv
// Round-robin scheduler: one grant at a time among 8 requesters, held until
// done, withdrawal or hold timeout, then priority rotates past the winner.
module rr_decode_scheduler
  import rr_sched_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNTW     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [NREQ-1:0] gnt_onehot,
  output logic            timeout
);

  localparam logic [CNTW-1:0] LP_LAST = CNTW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  state_t          r_state;
  logic [IDXW-1:0] r_ptr;
  logic [CNTW-1:0] r_cnt;
  logic            r_gnt_valid;
  logic [IDXW-1:0] r_gnt_idx;
  logic            r_timeout;

  state_t          w_state_nxt;
  logic [IDXW-1:0] w_ptr_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_gnt_valid_nxt;
  logic [IDXW-1:0] w_gnt_idx_nxt;
  logic            w_timeout_nxt;
  rel_cause_t      w_cause;
  logic [NREQ-1:0] w_dec;

  // Rotate right by ptr so bit 0 is the highest-priority requester, take the
  // lowest set bit, then translate back to an absolute index.
  function automatic logic [IDXW-1:0] f_rr_pick(input logic [NREQ-1:0] req_v,
                                                input logic [IDXW-1:0] ptr_v);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDXW-1:0]   off;
    logic              found;
    dbl   = {req_v, req_v} >> ptr_v;
    rot   = dbl[NREQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rot[i] && !found) begin
        off   = IDXW'(i);
        found = 1'b1;
      end
    end
    return ptr_v + off;
  endfunction

  // Completion outranks withdrawal, which outranks timeout.
  always_comb begin
    w_cause = REL_NONE;
    if (r_state == S_BUSY) begin
      if (done)                                  w_cause = REL_DONE;
      else if (!req[r_gnt_idx])                  w_cause = REL_WITHDRAW;
      else if (HOLD_MAX != 0 && r_cnt == LP_LAST) w_cause = REL_TIMEOUT;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_timeout_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req != '0) begin
          w_gnt_idx_nxt   = f_rr_pick(req, r_ptr);
          w_gnt_valid_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_cause != REL_NONE) begin
          w_gnt_valid_nxt = 1'b0;
          w_gnt_idx_nxt   = '0;
          w_ptr_nxt       = r_gnt_idx + IDXW'(1);
          w_cnt_nxt       = '0;
          w_timeout_nxt   = (w_cause == REL_TIMEOUT);
          w_state_nxt     = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  decoder_3to8 u_dec (
    .i_idx    (r_gnt_idx),
    .o_onehot (w_dec)
  );

  assign gnt_valid  = r_gnt_valid;
  assign gnt_idx    = r_gnt_idx;
  assign gnt_onehot = w_dec & {NREQ{r_gnt_valid}};
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_rr_decode_scheduler.sv
// Directed bench for rr_decode_scheduler with hand-computed expectations.
module tb_rr_decode_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_decode_scheduler #(.HOLD_MAX(16), .CNTW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [2:0] idx,
                         input logic [7:0] oh, input logic to);
    chk({tag, ".valid"},   32'(gnt_valid),  32'(v));
    chk({tag, ".idx"},     32'(gnt_idx),    32'(idx));
    chk({tag, ".onehot"},  32'(gnt_onehot), 32'(oh));
    chk({tag, ".timeout"}, 32'(timeout),    32'(to));
  endtask

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);

    // single request
    req = 8'h20;
    tick();
    chk_all("single_grant", 1'b1, 3'd5, 8'h20, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h41;
    chk_all("single_release", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk_all("ptr_after_5", 1'b1, 3'd6, 8'h40, 1'b0);
    done = 1'b1; tick(); done = 1'b0; req = '0; tick();

    // full rotation from a clean pointer
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_all($sformatf("rot%0d_grant", k), 1'b1, 3'(k % 8), 8'(1 << (k % 8)), 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_all($sformatf("rot%0d_gap", k), 1'b0, 3'd0, 8'h00, 1'b0);
    end
    req = '0; tick();

    // hold timeout: ptr is 1, only requester 0 active
    req = 8'h01;
    tick();
    chk_all("to_grant", 1'b1, 3'd0, 8'h01, 1'b0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      chk($sformatf("to_hold%0d", k), 32'(gnt_valid), 32'd1);
      chk($sformatf("to_nopulse%0d", k), 32'(timeout), 32'd0);
    end
    tick();
    chk_all("to_release", 1'b0, 3'd0, 8'h00, 1'b1);
    tick();
    chk_all("to_regrant", 1'b1, 3'd0, 8'h01, 1'b0);

    // done coincides with the last held cycle
    for (int k = 2; k <= 16; k++) tick();
    chk("coll_cycle16", 32'(gnt_valid), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_all("coll_release", 1'b0, 3'd0, 8'h00, 1'b0);
    req = '0; tick();
    chk("coll_no_late_pulse", 32'(timeout), 32'd0);

    // withdrawal: ptr is 1
    req = 8'h0C;
    tick();
    chk_all("wd_grant", 1'b1, 3'd2, 8'h04, 1'b0);
    req = 8'hF4;
    tick();
    chk_all("wd_other_bits", 1'b1, 3'd2, 8'h04, 1'b0);
    req = 8'h08;
    tick();
    chk_all("wd_release", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk_all("wd_next", 1'b1, 3'd3, 8'h08, 1'b0);
    done = 1'b1; tick(); done = 1'b0; req = '0; tick();

    // reset mid-grant: ptr is 4
    req = 8'h40;
    tick();
    chk_all("rst_grant6", 1'b1, 3'd6, 8'h40, 1'b0);
    rst = 1'b1; req = 8'hFF;
    tick();
    rst = 1'b0;
    chk_all("rst_cleared", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk_all("rst_first", 1'b1, 3'd0, 8'h01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
